// File: rtl/mem_pkg.sv
// Shared memory-side definitions: store size codes, serializer states
// and the size-to-beat-count helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic logic [2:0] beat_count(input logic [1:0] size);
        logic [2:0] n;
        n = 3'd1;
        case (size)
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    function automatic logic size_legal(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_select.sv
// Picks the big-endian byte for beat k from a left-justified word,
// so beat 0 is always the most-significant byte of the store.
module store_lane_select (
    input  logic [31:0] data_i,
    input  logic [1:0]  beat_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = data_i[31:24];
        case (beat_i)
            2'd0: byte_o = data_i[31:24];
            2'd1: byte_o = data_i[23:16];
            2'd2: byte_o = data_i[15:8];
            2'd3: byte_o = data_i[7:0];
            default: byte_o = data_i[31:24];
        endcase
    end

endmodule

// File: rtl/store_byte_serializer.sv
// Serializes SB/SH/SW stores big-endian onto a byte-wide memory port,
// stalling the pipeline via Busy until the last beat is acknowledged.
module store_byte_serializer
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  StoreValid,
    output logic                  StoreReady,
    input  logic [ADDR_WIDTH-1:0] StoreAddr,
    input  logic [31:0]           StoreData,
    input  logic [1:0]            StoreSize,
    output logic                  Busy,
    output logic                  StoreDone,
    output logic                  AlignErr,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [7:0]            MemData,
    output logic                  MemWrite,
    input  logic                  MemAck
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            beat_q, beat_d;
    logic [1:0]            last_q, last_d;
    logic [7:0]            byte_q, byte_d;
    logic                  wr_q, wr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [31:0] aligned;
    logic [31:0] lane_data;
    logic [1:0]  lane_beat;
    logic [7:0]  lane_byte;
    logic [2:0]  n_beats;
    logic        legal;

    // Left-justify so the lane selector never needs the size.
    assign aligned = (StoreSize == SZ_BYTE) ? {StoreData[7:0], 24'h0} :
                     (StoreSize == SZ_HALF) ? {StoreData[15:0], 16'h0} :
                     StoreData;

    assign n_beats = beat_count(StoreSize);
    assign legal   = size_legal(StoreSize, StoreAddr[1:0]);

    // In IDLE the lane looks at the incoming store; in WRITE, the next beat.
    assign lane_data = (state_q == ST_IDLE) ? aligned : data_q;
    assign lane_beat = (state_q == ST_IDLE) ? 2'd0 : beat_q + 2'd1;

    store_lane_select u_lane (
        .data_i (lane_data),
        .beat_i (lane_beat),
        .byte_o (lane_byte)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        beat_d  = beat_q;
        last_d  = last_q;
        byte_d  = byte_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (StoreValid) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = StoreAddr;
                        data_d  = aligned;
                        beat_d  = 2'd0;
                        last_d  = 2'(n_beats - 3'd1);
                        byte_d  = lane_byte;
                        wr_d    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (MemAck) begin
                    if (beat_q == last_q) begin
                        state_d = ST_IDLE;
                        wr_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        byte_d = lane_byte;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            byte_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Busy       = (state_q == ST_WRITE);
    assign StoreReady = ~Busy;
    assign MemAddr    = addr_q;
    assign MemData    = byte_q;
    assign MemWrite   = wr_q;
    assign StoreDone  = done_q;
    assign AlignErr   = err_q;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Directed bench for store_byte_serializer.
// SB/SH/SW, illegal, wait, b2b, reset mid-store.
module tb_store_byte_serializer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        StoreValid;
  logic        StoreReady;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;
  logic [1:0]  StoreSize;
  logic        Busy;
  logic        StoreDone;
  logic        AlignErr;
  logic [31:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemWrite;
  logic        MemAck;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  store_byte_serializer #(.ADDR_WIDTH(32)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .StoreValid (StoreValid),
    .StoreReady (StoreReady),
    .StoreAddr  (StoreAddr),
    .StoreData  (StoreData),
    .StoreSize  (StoreSize),
    .Busy       (Busy),
    .StoreDone  (StoreDone),
    .AlignErr   (AlignErr),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .MemWrite   (MemWrite),
    .MemAck     (MemAck)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0] s);
    StoreValid = 1'b1;
    StoreAddr  = a;
    StoreData  = d;
    StoreSize  = s;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    StoreValid = 1'b0;
    StoreAddr = '0;
    StoreData = '0;
    StoreSize = '0;
    MemAck = 1'b0;
    tick();
    tick();
    checks++;
    if ({MemWrite, StoreDone, AlignErr, Busy, StoreReady}
        !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got %b want 00001",
        {MemWrite, StoreDone, AlignErr, Busy, StoreReady});
    end
    checks++;
    if ({MemAddr, MemData} !== 40'h0) begin
      errors++;
      $display("FAIL reset_mem got %h/%h want 0/0",
        MemAddr, MemData);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_sw;
    logic [7:0] ed [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    drive(32'h100, 32'hDEADBEEF, 2'b10);
    MemAck = 1'b1;
    checks++;
    if (StoreReady !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready got %b want 1", StoreReady);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({MemWrite, Busy, StoreDone, MemAddr, MemData} !==
          {3'b110, 32'(32'h100 + k), ed[k]}) begin
        errors++;
        $display("FAIL sw_beat%0d got %b%b%b %h/%h want 110 %h/%h",
          k, MemWrite, Busy, StoreDone, MemAddr, MemData,
          32'(32'h100 + k), ed[k]);
      end
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if ({StoreDone, MemWrite, Busy, StoreReady} !== 4'b1001) begin
      errors++;
      $display("FAIL sw_done got %b want 1001",
        {StoreDone, MemWrite, Busy, StoreReady});
    end
    tick();
    checks++;
    if (StoreDone !== 1'b0) begin
      errors++;
      $display("FAIL sw_done_pulse got %b want 0", StoreDone);
    end
  endtask

  task automatic test_trunc;
    logic [7:0] ed [2] = '{8'h56, 8'h78};
    drive(32'h202, 32'h12345678, 2'b01);
    MemAck = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({MemWrite, MemAddr, MemData} !==
          {1'b1, 32'(32'h202 + k), ed[k]}) begin
        errors++;
        $display("FAIL sh_beat%0d got w%b %h/%h want 1 %h/%h", k,
          MemWrite, MemAddr, MemData, 32'(32'h202 + k), ed[k]);
      end
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if ({StoreDone, MemWrite} !== 2'b10) begin
      errors++;
      $display("FAIL sh_done got %b want 10",
        {StoreDone, MemWrite});
    end
    tick();
    drive(32'h203, 32'hFFFFFF9A, 2'b00);
    tick();
    checks++;
    if ({MemWrite, MemAddr, MemData}
        !== {1'b1, 32'h203, 8'h9A}) begin
      errors++;
      $display("FAIL sb_beat got w%b %h/%h want 1 203/9a",
        MemWrite, MemAddr, MemData);
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if ({StoreDone, MemWrite, Busy} !== 3'b100) begin
      errors++;
      $display("FAIL sb_done got %b want 100",
        {StoreDone, MemWrite, Busy});
    end
    tick();
  endtask

  task automatic test_illegal;
    logic [31:0] ad [3] = '{32'h101, 32'h301, 32'h0};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    MemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ad[i], 32'h55555555, sz[i]);
      tick();
      StoreValid = 1'b0;
      checks++;
      if ({AlignErr, MemWrite, StoreDone, StoreReady, Busy}
          !== 5'b10010) begin
        errors++;
        $display("FAIL illegal%0d got %b want 10010", i,
          {AlignErr, MemWrite, StoreDone, StoreReady, Busy});
      end
      tick();
      checks++;
      if ({AlignErr, MemWrite, StoreReady} !== 3'b001) begin
        errors++;
        $display("FAIL illegal%0d_after got %b want 001", i,
          {AlignErr, MemWrite, StoreReady});
      end
    end
  endtask

  task automatic test_wait;
    logic [31:0] ea [7] = '{32'h400, 32'h401, 32'h401, 32'h401,
                            32'h401, 32'h402, 32'h403};
    logic [7:0]  ed [7] = '{8'h11, 8'h22, 8'h22, 8'h22,
                            8'h22, 8'h33, 8'h44};
    logic        ak [7] = '{1'b1, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1};
    drive(32'h400, 32'h11223344, 2'b10);
    MemAck = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      MemAck = ak[c];
      checks++;
      if ({MemWrite, StoreDone, MemAddr, MemData} !==
          {2'b10, ea[c], ed[c]}) begin
        errors++;
        $display("FAIL wait_cyc%0d got %b%b %h/%h want 10 %h/%h",
          c + 1, MemWrite, StoreDone, MemAddr, MemData,
          ea[c], ed[c]);
      end
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if ({StoreDone, MemWrite} !== 2'b10) begin
      errors++;
      $display("FAIL wait_done got %b want 10",
        {StoreDone, MemWrite});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    MemAck = 1'b1;
    drive(32'h10, 32'h000000A5, 2'b00);
    tick();
    checks++;
    if ({MemWrite, MemAddr, MemData}
        !== {1'b1, 32'h10, 8'hA5}) begin
      errors++;
      $display("FAIL b2b_first got w%b %h/%h want 1 10/a5",
        MemWrite, MemAddr, MemData);
    end
    tick();
    drive(32'h11, 32'hFFFFFF3C, 2'b00);
    checks++;
    if ({StoreDone, StoreReady} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_done got %b want 11",
        {StoreDone, StoreReady});
    end
    tick();
    checks++;
    if ({MemWrite, Busy, MemAddr, MemData}
        !== {2'b11, 32'h11, 8'h3C}) begin
      errors++;
      $display("FAIL b2b_second got %b %h/%h want 11 11/3c",
        {MemWrite, Busy}, MemAddr, MemData);
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if (StoreDone !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got %b want 1", StoreDone);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    MemAck = 1'b1;
    drive(32'h500, 32'hCAFEF00D, 2'b10);
    tick();
    tick();
    checks++;
    if ({MemWrite, MemAddr, MemData}
        !== {1'b1, 32'h501, 8'hFE}) begin
      errors++;
      $display("FAIL rst_mid_beat1 got w%b %h/%h want 1 501/fe",
        MemWrite, MemAddr, MemData);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    StoreValid = 1'b0;
    checks++;
    if ({MemWrite, StoreDone, AlignErr, Busy, StoreReady,
         MemAddr, MemData} !== {5'b00001, 32'h0, 8'h0}) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b %h/%h want 00001 0/0",
        {MemWrite, StoreDone, AlignErr, Busy, StoreReady},
        MemAddr, MemData);
    end
    tick();
    checks++;
    if ({StoreDone, MemWrite} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_nodone got %b want 00",
        {StoreDone, MemWrite});
    end
    drive(32'h600, 32'h12345677, 2'b00);
    tick();
    checks++;
    if ({MemWrite, MemAddr, MemData}
        !== {1'b1, 32'h600, 8'h77}) begin
      errors++;
      $display("FAIL rst_mid_sb got w%b %h/%h want 1 600/77",
        MemWrite, MemAddr, MemData);
    end
    tick();
    StoreValid = 1'b0;
    checks++;
    if ({StoreDone, MemWrite} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_sb_done got %b want 10",
        {StoreDone, MemWrite});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_trunc();
    test_illegal();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_byte_serializer.md
# store_byte_serializer

Store-side counterpart to the pipeline's immediate/load extenders. It accepts a 32-bit register value with a size code from the MEM stage, truncates it to byte, halfword or word, and writes it big-endian, one byte per beat, to the byte-wide data memory port. It holds the pipeline via `Busy` until the last byte is acknowledged. It sits between the EX/MEM register and data memory.

## Interface
- `ADDR_WIDTH`, default 32: width of the store and memory addresses.
- `Clk`  in  1: rising-edge clock.
- `Rst`  in  1: synchronous, active-high reset.
- `StoreValid`  in  1: store request from the MEM stage.
- `StoreReady`  out  1: block can accept a request this cycle.
- `StoreAddr`  in  ADDR_WIDTH: byte address of the store.
- `StoreData`  in  32: register value (rt).
- `StoreSize`  in  2: 00 = byte (SB), 01 = half (SH), 10 = word (SW), 11 = illegal.
- `Busy`  out  1: pipeline stall request.
- `StoreDone`  out  1: one-cycle pulse when a store completes.
- `AlignErr`  out  1: one-cycle pulse when a request is rejected.
- `MemAddr`  out  ADDR_WIDTH: byte address of the current beat.
- `MemData`  out  8: byte for the current beat.
- `MemWrite`  out  1: write strobe, held until acknowledged.
- `MemAck`  in  1: memory accepted the current beat.

## Operation
- **States.** `IDLE` and `WRITE`.
- **Acceptance.** In `IDLE`, `StoreReady` = 1. A request is accepted when `StoreValid` && `StoreReady`.
- **Legality check at acceptance.**
  - SH is illegal when `StoreAddr[0]` != 0.
  - SW is illegal when `StoreAddr[1:0]` != 0.
  - Size 11 is always illegal.
  - For an illegal request: `AlignErr` = 1 next cycle, no memory beat, state stays `IDLE`.
- **Legal request.**
  - Latch the address, the truncated data and beat count N (SB = 1, SH = 2, SW = 4).
  - Clear the beat index k.
  - Go to `WRITE`.
- **Truncation.** SB uses `StoreData[7:0]`, SH uses `StoreData[15:0]`, SW uses `StoreData[31:0]`. Discarded upper bits do not affect any output.
- **Byte order (big-endian).** Beat k carries the most-significant remaining byte at `MemAddr` = base + k.
  - SW: beat 0 = `[31:24]`, beat 1 = `[23:16]`, beat 2 = `[15:8]`, beat 3 = `[7:0]`.
  - SH: beat 0 = `[15:8]`, beat 1 = `[7:0]`.
  - SB: beat 0 = `[7:0]`.
- **`WRITE` state.**
  - `MemWrite` = 1, and `MemAddr`/`MemData` are stable until `MemAck` is sampled high.
  - On ack with k < N-1: k increments and the next beat is presented the following cycle.
  - On ack with k = N-1: go to `IDLE`, and pulse `StoreDone` in the first `IDLE` cycle.
- **`Busy`.** `Busy` = (state == `WRITE`). `StoreReady` = !`Busy`.
- **Back-to-back stores.** A new request can be accepted in the same cycle that `StoreDone` is high.
- **Ignored inputs.** `MemAck` is ignored in `IDLE`. `StoreValid` is ignored in `WRITE`; the requester must hold it while `Busy`.
- **Address arithmetic.** Beat address is base + k, modulo 2^ADDR_WIDTH. Legal aligned requests never wrap within a store.

## Timing
- **Reset values.**
  - State `IDLE`.
  - `MemWrite`, `StoreDone`, `AlignErr`, `Busy` = 0.
  - `StoreReady` = 1.
  - `MemAddr` = 0, `MemData` = 0.
- **Reset mid-store.** `Rst` mid-store drops `MemWrite` on the next edge. The remaining beats are abandoned and no `StoreDone` pulse is issued.
- **Latency with `MemAck` tied high** (accept at cycle 0):
  - `MemWrite` high in cycles 1..N.
  - `StoreDone` in cycle N+1.
  - SW: 4 write cycles, done at cycle 5.
- **Wait states.** Each cycle `MemAck` stays low extends the current beat by one cycle.
- **Registered outputs.** All outputs are registered except `StoreReady` and `Busy`, which decode the registered state.
- **Output separation.** `AlignErr` and `StoreDone` are never high in the same cycle.

## Structure
- **Package `mem_pkg`.**
  - Size codes: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State encoding: `ST_IDLE`, `ST_WRITE`.
  - Beat-count function (size to N).
- **Sub-module `store_lane_select`.** Combinational; takes the latched data and k, and returns the big-endian byte for that beat. It is shared later with the load-side assembler.

## Test plan
- **SW, ack tied high.** addr 0x100, data 0xDEADBEEF, size 10 -> beats (0x100,DE), (0x101,AD), (0x102,BE), (0x103,EF) in cycles 1-4; `StoreDone` in cycle 5; `Busy` high in cycles 1-4.
- **SH and SB truncation.** SH addr 0x202, data 0x12345678 -> (0x202,56), (0x203,78). SB addr 0x203, data 0xFFFFFF9A -> (0x203,9A) only.
- **Misalignment and illegal size.** SW addr 0x101, SH addr 0x301 and size 11 -> `AlignErr` pulse each; `MemWrite` never asserts; `StoreReady` stays 1.
- **Wait states.** SW with `MemAck` low for 3 cycles on beat 1 -> beat 1 address/data held for 4 cycles; completion at cycle 8; byte order unchanged.
- **Back-to-back.** Second SB presented in the `StoreDone` cycle -> accepted that cycle; its beat appears on the next cycle.
- **Reset mid-store.** `Rst` asserted after beat 1 of an SW -> `MemWrite` = 0 next cycle; no `StoreDone`; all outputs at reset values; a subsequent SB completes normally.
